// File: rtl/alu_issue_pkg.sv
// ============================================================================
// Module : alu_issue_pkg
// Desc   : Opcodes, action-word field offsets and FSM encoding shared by the
//          ALU issue/collect stage.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package alu_issue_pkg;

  localparam logic [3:0] OP_NOP  = 4'b0000;
  localparam logic [3:0] OP_ADD  = 4'b0001;
  localparam logic [3:0] OP_SUB  = 4'b0010;
  localparam logic [3:0] OP_ADDI = 4'b1001;
  localparam logic [3:0] OP_SUBI = 4'b1010;
  localparam logic [3:0] OP_SET  = 4'b1110;

  localparam int OPC_LSB  = 21;
  localparam int OPC_W    = 4;
  localparam int IDX1_LSB = 18;
  localparam int IDX2_LSB = 15;
  localparam int IMM_LSB  = 0;
  localparam int IMM_W    = 15;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_OUT   = 2'd3
  } state_t;

endpackage

`default_nettype wire

// File: rtl/alu_operand_sel.sv
// ============================================================================
// Module : alu_operand_sel
// Desc   : Per-slot operand mux: picks op1/op2 from the PHV or the immediate.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module alu_operand_sel
  import alu_issue_pkg::*;
#(
  parameter int NUM_CONT   = 8,
  parameter int DATA_WIDTH = 48,
  parameter int ACTION_LEN = 25,
  parameter int IDX_W      = 3,
  parameter int SLOT       = 0
) (
  input  logic [NUM_CONT*DATA_WIDTH-1:0] phv,
  input  logic [ACTION_LEN-1:0]          action,
  output logic [DATA_WIDTH-1:0]          op1,
  output logic [DATA_WIDTH-1:0]          op2
);

  logic [OPC_W-1:0]      w_opc;
  logic [IDX_W-1:0]      w_idx1;
  logic [IDX_W-1:0]      w_idx2;
  logic [IMM_W-1:0]      w_imm;
  logic [IDX_W-1:0]      w_sel1;
  logic [DATA_WIDTH-1:0] w_phv2;

  assign w_opc  = action[OPC_LSB  +: OPC_W];
  assign w_idx1 = action[IDX1_LSB +: IDX_W];
  assign w_idx2 = action[IDX2_LSB +: IDX_W];
  assign w_imm  = action[IMM_LSB  +: IMM_W];

  // A no-op reads the slot's own container so the PHV passes through untouched.
  assign w_sel1 = (w_opc == OP_NOP) ? IDX_W'(SLOT) : w_idx1;

  always_comb begin
    op1    = '0;
    w_phv2 = '0;
    // Indices with no matching container leave the operand at zero.
    for (int j = 0; j < NUM_CONT; j++) begin
      if (int'(w_sel1) == j) op1    = phv[j*DATA_WIDTH +: DATA_WIDTH];
      if (int'(w_idx2) == j) w_phv2 = phv[j*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  always_comb begin
    op2 = '0;
    case (w_opc)
      OP_ADD, OP_SUB:           op2 = w_phv2;
      OP_ADDI, OP_SUBI, OP_SET: op2 = {{(DATA_WIDTH-IMM_W){1'b0}}, w_imm};
      default:                  op2 = '0;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/alu_issue_collect.sv
// ============================================================================
// Module : alu_issue_collect
// Desc   : Issues one PHV to a bank of ALUs in a single strobe and collects the
//          returned containers into an output PHV with valid/ready handoff.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module alu_issue_collect
  import alu_issue_pkg::*;
#(
  parameter int NUM_CONT   = 8,
  parameter int DATA_WIDTH = 48,
  parameter int ACTION_LEN = 25,
  parameter int IDX_W      = 3,
  parameter int TIMEOUT    = 8
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [NUM_CONT*DATA_WIDTH-1:0] phv_in,
  input  logic [NUM_CONT*ACTION_LEN-1:0] action_vliw_in,
  input  logic                           phv_in_valid,
  output logic                           phv_in_ready,
  output logic [NUM_CONT*ACTION_LEN-1:0] alu_action_out,
  output logic                           alu_action_valid,
  output logic [NUM_CONT*DATA_WIDTH-1:0] alu_op1_out,
  output logic [NUM_CONT*DATA_WIDTH-1:0] alu_op2_out,
  input  logic [NUM_CONT*DATA_WIDTH-1:0] alu_container_in,
  input  logic [NUM_CONT-1:0]            alu_container_valid_in,
  output logic [NUM_CONT*DATA_WIDTH-1:0] phv_out,
  output logic                           phv_out_valid,
  input  logic                           phv_out_ready,
  output logic                           err_timeout
);

  localparam int PW    = NUM_CONT*DATA_WIDTH;
  localparam int AW    = NUM_CONT*ACTION_LEN;
  localparam int CNT_W = $clog2(TIMEOUT+1);

  logic [PW-1:0] w_op1;
  logic [PW-1:0] w_op2;

  state_t             state_q,     state_d;
  logic [PW-1:0]      phv_q,       phv_d;
  logic [AW-1:0]      act_q,       act_d;
  logic               act_valid_q, act_valid_d;
  logic [PW-1:0]      op1_q,       op1_d;
  logic [PW-1:0]      op2_q,       op2_d;
  logic [NUM_CONT-1:0] mask_q,     mask_d;
  logic [CNT_W-1:0]   cnt_q,       cnt_d;
  logic               ready_q,     ready_d;
  logic [PW-1:0]      out_q,       out_d;
  logic               out_valid_q, out_valid_d;
  logic               err_q,       err_d;

  generate
    for (genvar i = 0; i < NUM_CONT; i++) begin : g_slot
      alu_operand_sel #(
        .NUM_CONT   (NUM_CONT),
        .DATA_WIDTH (DATA_WIDTH),
        .ACTION_LEN (ACTION_LEN),
        .IDX_W      (IDX_W),
        .SLOT       (i)
      ) u_sel (
        .phv    (phv_in),
        .action (action_vliw_in[i*ACTION_LEN +: ACTION_LEN]),
        .op1    (w_op1[i*DATA_WIDTH +: DATA_WIDTH]),
        .op2    (w_op2[i*DATA_WIDTH +: DATA_WIDTH])
      );
    end
  endgenerate

  always_comb begin
    state_d     = state_q;
    phv_d       = phv_q;
    act_d       = act_q;
    act_valid_d = 1'b0;
    op1_d       = op1_q;
    op2_d       = op2_q;
    mask_d      = mask_q;
    cnt_d       = cnt_q;
    ready_d     = ready_q;
    out_d       = out_q;
    out_valid_d = out_valid_q;
    err_d       = 1'b0;

    case (state_q)
      ST_IDLE: begin
        ready_d = 1'b1;
        // ready_q gates the accept so nothing is taken in the first cycle after reset.
        if (ready_q && phv_in_valid) begin
          phv_d       = phv_in;
          act_d       = action_vliw_in;
          op1_d       = w_op1;
          op2_d       = w_op2;
          act_valid_d = 1'b1;
          ready_d     = 1'b0;
          state_d     = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        mask_d  = '0;
        cnt_d   = '0;
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        for (int i = 0; i < NUM_CONT; i++) begin
          if (alu_container_valid_in[i]) begin
            out_d[i*DATA_WIDTH +: DATA_WIDTH] = alu_container_in[i*DATA_WIDTH +: DATA_WIDTH];
            mask_d[i] = 1'b1;
          end
        end
        cnt_d = cnt_q + 1'b1;
        if (&mask_d) begin
          out_valid_d = 1'b1;
          state_d     = ST_OUT;
        end else if (cnt_q == CNT_W'(TIMEOUT-1)) begin
          // Slots that never answered fall back to their original container.
          err_d = 1'b1;
          for (int i = 0; i < NUM_CONT; i++) begin
            if (!mask_d[i]) out_d[i*DATA_WIDTH +: DATA_WIDTH] = phv_q[i*DATA_WIDTH +: DATA_WIDTH];
          end
          out_valid_d = 1'b1;
          state_d     = ST_OUT;
        end
      end
      ST_OUT: begin
        if (phv_out_ready) begin
          out_valid_d = 1'b0;
          ready_d     = 1'b1;
          state_d     = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      phv_q       <= '0;
      act_q       <= '0;
      act_valid_q <= 1'b0;
      op1_q       <= '0;
      op2_q       <= '0;
      mask_q      <= '0;
      cnt_q       <= '0;
      ready_q     <= 1'b0;
      out_q       <= '0;
      out_valid_q <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      phv_q       <= phv_d;
      act_q       <= act_d;
      act_valid_q <= act_valid_d;
      op1_q       <= op1_d;
      op2_q       <= op2_d;
      mask_q      <= mask_d;
      cnt_q       <= cnt_d;
      ready_q     <= ready_d;
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
      err_q       <= err_d;
    end
  end

  assign phv_in_ready     = ready_q;
  assign alu_action_out   = act_q;
  assign alu_action_valid = act_valid_q;
  assign alu_op1_out      = op1_q;
  assign alu_op2_out      = op2_q;
  assign phv_out          = out_q;
  assign phv_out_valid    = out_valid_q;
  assign err_timeout      = err_q;

endmodule

`default_nettype wire

// File: tb/tb_alu_issue_collect.sv
// ============================================================================
// Module : tb_alu_issue_collect
// Desc   : Directed bench for alu_issue_collect with a two-cycle ALU model.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_alu_issue_collect;

  localparam int NC = 8;
  localparam int DW = 48;
  localparam int AL = 25;
  localparam int PW = NC*DW;
  localparam int AW = NC*AL;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [PW-1:0] phv_in = '0;
  logic [AW-1:0] action_vliw_in = '0;
  logic          phv_in_valid = 1'b0;
  logic          phv_in_ready;
  logic [AW-1:0] alu_action_out;
  logic          alu_action_valid;
  logic [PW-1:0] alu_op1_out;
  logic [PW-1:0] alu_op2_out;
  logic [PW-1:0] alu_container_in = '0;
  logic [NC-1:0] alu_container_valid_in = '0;
  logic [PW-1:0] phv_out;
  logic          phv_out_valid;
  logic          phv_out_ready = 1'b1;
  logic          err_timeout;

  int n_checks = 0;
  int n_fail   = 0;

  alu_issue_collect dut (
    .clk                    (clk),
    .rst_n                  (rst_n),
    .phv_in                 (phv_in),
    .action_vliw_in         (action_vliw_in),
    .phv_in_valid           (phv_in_valid),
    .phv_in_ready           (phv_in_ready),
    .alu_action_out         (alu_action_out),
    .alu_action_valid       (alu_action_valid),
    .alu_op1_out            (alu_op1_out),
    .alu_op2_out            (alu_op2_out),
    .alu_container_in       (alu_container_in),
    .alu_container_valid_in (alu_container_valid_in),
    .phv_out                (phv_out),
    .phv_out_valid          (phv_out_valid),
    .phv_out_ready          (phv_out_ready),
    .err_timeout            (err_timeout)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [PW-1:0] got, input logic [PW-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [AL-1:0] act(input logic [3:0] op, input logic [2:0] i1,
                                        input logic [2:0] i2, input logic [14:0] imm);
    return {op, i1, i2, imm};
  endfunction

  function automatic logic [DW-1:0] slot(input logic [PW-1:0] v, input int i);
    return v[i*DW +: DW];
  endfunction

  // ALU model: strobe seen at edge N, results valid during the cycle after edge N+1.
  logic [NC-1:0] sup_mask    = '0;
  logic [NC-1:0] stray_valid = '0;
  logic          s1          = 1'b0;
  logic [PW-1:0] res1        = '0;

  function automatic logic [DW-1:0] alu_f(input logic [AL-1:0] a, input logic [DW-1:0] x,
                                          input logic [DW-1:0] y);
    logic [3:0] op;
    op = a[24:21];
    case (op)
      4'b0001, 4'b1001: return x + y;
      4'b0010, 4'b1010: return x - y;
      4'b1110:          return y;
      default:          return x;
    endcase
  endfunction

  always @(posedge clk) begin
    s1 <= alu_action_valid;
    for (int i = 0; i < NC; i++)
      res1[i*DW +: DW] <= alu_f(alu_action_out[i*AL +: AL], alu_op1_out[i*DW +: DW],
                                alu_op2_out[i*DW +: DW]);
    alu_container_valid_in <= (s1 ? ~sup_mask : '0) | stray_valid;
    alu_container_in       <= s1 ? res1 : {NC{48'hDEAD_BEEF_0000}};
  end

  logic          iss_valid1, iss_valid2;
  logic [PW-1:0] iss_op1, iss_op2;

  // Send one PHV, wait for phv_out_valid, optionally stall the downstream, then drain.
  task automatic do_phv(input logic [PW-1:0] p, input logic [AW-1:0] v, input logic [NC-1:0] sup,
                        input int hold, output logic [PW-1:0] res, output int lat, output int errs);
    int n;
    n = 0;
    sup_mask = sup;
    while (!phv_in_ready && n < 20) begin @(negedge clk); n++; end
    check("in_ready_before_send", PW'(phv_in_ready), PW'(1));
    phv_in = p; action_vliw_in = v; phv_in_valid = 1'b1; phv_out_ready = (hold == 0);
    @(negedge clk);
    phv_in_valid = 1'b0;
    iss_valid1 = alu_action_valid; iss_op1 = alu_op1_out; iss_op2 = alu_op2_out;
    lat = 1; errs = 0;
    while (!phv_out_valid && lat < 30) begin
      if (err_timeout) errs++;
      @(negedge clk); lat++;
      if (lat == 2) iss_valid2 = alu_action_valid;
    end
    if (err_timeout) errs++;
    res = phv_out;
    check("out_valid_seen", PW'(phv_out_valid), PW'(1));
    for (int k = 0; k < hold; k++) begin
      @(negedge clk);
      if (err_timeout) errs++;
      check("hold_phv_stable", phv_out, res);
      check("hold_in_ready_low", PW'(phv_in_ready), PW'(0));
      check("hold_out_valid", PW'(phv_out_valid), PW'(1));
    end
    phv_out_ready = 1'b1;
    @(negedge clk);
    check("out_valid_dropped", PW'(phv_out_valid), PW'(0));
    check("idle_after_handshake", PW'(phv_in_ready), PW'(1));
  endtask

  logic [PW-1:0] p1, e1, p2, e2, res, bp [3], outs [3];
  logic [AW-1:0] v1, v2, vnop;
  int lat, errs, acc [3], k, o, cyc;

  initial begin
    for (int i = 0; i < NC; i++) p1[i*DW +: DW] = DW'(48'h100 + i);
    p1[1*DW +: DW] = 48'd5; p1[2*DW +: DW] = 48'd7; p1[3*DW +: DW] = 48'h30;
    vnop = '0; v1 = '0;
    v1[0*AL +: AL] = act(4'b0001, 3'd1, 3'd2, 15'h0);
    v1[3*AL +: AL] = act(4'b1010, 3'd3, 3'd0, 15'h10);
    v1[6*AL +: AL] = act(4'b1110, 3'd6, 3'd0, 15'h7FFF);
    e1 = p1;
    e1[0*DW +: DW] = 48'd12; e1[3*DW +: DW] = 48'h20; e1[6*DW +: DW] = 48'h7FFF;

    for (int i = 0; i < NC; i++) p2[i*DW +: DW] = DW'(48'h200 + i);
    v2 = '0;
    v2[0*AL +: AL] = act(4'b1001, 3'd0, 3'd0, 15'h1);
    v2[5*AL +: AL] = act(4'b0001, 3'd5, 3'd5, 15'h0);
    e2 = p2; e2[0*DW +: DW] = 48'h201;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_in_ready", PW'(phv_in_ready), PW'(0));
    check("rst_phv_out", phv_out, '0);
    check("rst_ctrl", PW'({alu_action_valid, phv_out_valid, err_timeout}), PW'(0));
    rst_n = 1'b1;
    @(negedge clk);
    check("ready_first_cycle", PW'(phv_in_ready), PW'(1));

    // ADD / SUBI / SET with no-op passthrough
    do_phv(p1, v1, '0, 0, res, lat, errs);
    check("issue_strobe_c1", PW'(iss_valid1), PW'(1));
    check("issue_strobe_c2", PW'(iss_valid2), PW'(0));
    check("op1_slot0", PW'(slot(iss_op1, 0)), PW'(5));
    check("op2_slot0", PW'(slot(iss_op2, 0)), PW'(7));
    check("op2_slot3_imm", PW'(slot(iss_op2, 3)), PW'(16'h10));
    check("op1_slot4_nop", PW'(slot(iss_op1, 4)), PW'(16'h104));
    check("op2_slot4_nop", PW'(slot(iss_op2, 4)), PW'(0));
    check("latency_nominal", PW'(lat), PW'(4));
    check("phv_out_alu", res, e1);
    check("no_err_nominal", PW'(errs), PW'(0));

    // Slot 5 never answers; downstream stalled for 6 cycles
    do_phv(p2, v2, 8'h20, 6, res, lat, errs);
    check("latency_timeout", PW'(lat), PW'(10));
    check("err_pulses", PW'(errs), PW'(1));
    check("phv_out_timeout", res, e2);

    // Stray ALU valid in IDLE
    stray_valid = 8'hFF;
    @(negedge clk); stray_valid = '0;
    repeat (2) @(negedge clk);
    check("stray_phv_out", phv_out, e2);
    check("stray_out_valid", PW'(phv_out_valid), PW'(0));

    // Back-to-back with phv_in_valid held high
    sup_mask = '0; phv_out_ready = 1'b1; action_vliw_in = vnop;
    for (int b = 0; b < 3; b++)
      for (int i = 0; i < NC; i++) bp[b][i*DW +: DW] = DW'(b*16 + i + 1);
    k = 0; o = 0; cyc = 0;
    phv_in = bp[0]; phv_in_valid = 1'b1;
    while (cyc < 40 && o < 3) begin
      if (phv_in_ready) begin
        if (k < 3) begin phv_in = bp[k]; acc[k] = cyc; k++; end
        else phv_in_valid = 1'b0;
      end
      @(negedge clk); cyc++;
      if (phv_out_valid && o < 3) begin outs[o] = phv_out; o++; end
    end
    phv_in_valid = 1'b0;
    check("b2b_outputs", PW'(o), PW'(3));
    check("b2b_gap01", PW'(acc[1] - acc[0]), PW'(5));
    check("b2b_gap12", PW'(acc[2] - acc[1]), PW'(5));
    for (int b = 0; b < 3; b++) check($sformatf("b2b_phv%0d", b), outs[b], bp[b]);
    repeat (2) @(negedge clk);

    // Reset asserted during WAIT
    phv_in = p1; action_vliw_in = v1; phv_in_valid = 1'b1;
    @(negedge clk); phv_in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrst_phv_out", phv_out, '0);
    check("midrst_ops", alu_op1_out | alu_op2_out, '0);
    check("midrst_ctrl", PW'({phv_in_ready, alu_action_valid, phv_out_valid, err_timeout}), PW'(0));
    repeat (3) @(negedge clk);
    check("midrst_late_valid", phv_out, '0);
    rst_n = 1'b1;
    do_phv(p1, v1, '0, 0, res, lat, errs);
    check("post_rst_phv", res, e1);
    check("post_rst_latency", PW'(lat), PW'(4));

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
